// File: rtl/fsm_pkg.sv
// -----------------------------------------------------------------------------
// fsm_pkg
// Shared definitions for the key_bit_sampler front-end:
//   - key_state_t : debounce FSM states
//   - CLK_HZ      : nominal system clock (CLOCK_50)
//   - DEFAULT_*   : default debounce / history / auto-repeat constants
//   - cnt_width() : width of a counter that must reach max(a, b) - 1
// -----------------------------------------------------------------------------
package fsm_pkg;

  localparam int CLK_HZ                  = 50_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 250_000;     // 5 ms at 50 MHz
  localparam int DEFAULT_HIST_LEN        = 4;
  localparam int DEFAULT_REPEAT_CYCLES   = 25_000_000;  // 0.5 s at 50 MHz

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

  // A counter that counts 0 .. max(a, b) - 1 needs clog2(max(a, b)) bits,
  // never fewer than one.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous input.
// Parameters:
//   RESET_VALUE - value both flops take while reset is asserted
// Ports:
//   clock - system clock
//   reset - asynchronous, active-high
//   d     - asynchronous input
//   q     - synchronized output (two clocks of latency)
// -----------------------------------------------------------------------------
module sync2 #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta and q update together at the
  // edge; blocking ones would let d fall straight through to q in one clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_bit_sampler.sv
// -----------------------------------------------------------------------------
// key_bit_sampler
// Turns a bouncy active-low pushbutton plus a data switch into a clean,
// single-cycle bit strobe in the system clock domain, and keeps a short
// history of accepted bits for the display path.
//
// Optional build macro:
//   KEY_BIT_SAMPLER_AUTO_REPEAT_EN - while the key stays pressed, issue a
//   further accept every REPEAT_CYCLES clocks. Undefined: one bit per press.
//
// Parameters:
//   DEBOUNCE_CYCLES - clocks the key must be stable to accept a press/release (>= 2)
//   HIST_LEN        - number of accepted bits kept in history
//   REPEAT_CYCLES   - auto-repeat period while held (auto-repeat builds only)
// Ports:
//   clock     - system clock
//   reset     - asynchronous, active-high; clears all state
//   key_n     - raw pushbutton, active-low, asynchronous
//   sw        - raw data switch, asynchronous
//   bit_valid - one-cycle strobe: a new bit has been accepted
//   bit_out   - accepted bit; holds last accepted value between strobes
//   history   - accepted bits, newest at bit 0
//   bit_count - number of accepted bits, modulo 256
// -----------------------------------------------------------------------------
module key_bit_sampler
  import fsm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HIST_LEN        = DEFAULT_HIST_LEN,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                key_n,
  input  logic                sw,
  output logic                bit_valid,
  output logic                bit_out,
  output logic [HIST_LEN-1:0] history,
  output logic [7:0]          bit_count
);

  localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_s;
  logic             sw_s;
  key_state_t       state;
  logic [CNT_W-1:0] deb_cnt;
  logic             press_done;
  logic             rpt_fire;
  logic             accept;

  // Idle key level is high (released), so its synchronizer resets to 1 and a
  // held key is seen as a fresh press once reset lifts.
  sync2 #(.RESET_VALUE(1'b1)) u_sync_key (
    .clock (clock),
    .reset (reset),
    .d     (key_n),
    .q     (key_s)
  );

  sync2 #(.RESET_VALUE(1'b0)) u_sync_sw (
    .clock (clock),
    .reset (reset),
    .d     (sw),
    .q     (sw_s)
  );

`ifdef KEY_BIT_SAMPLER_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rpt_cnt;

  // Runs only while settled in PRESSED with the key still down; anything
  // else holds it at zero, so every entry to PRESSED starts a full period.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rpt_cnt <= '0;
    end else if (state == PRESSED && !key_s) begin
      rpt_cnt <= rpt_fire ? '0 : rpt_cnt + 1'b1;
    end else begin
      rpt_cnt <= '0;
    end
  end

  assign rpt_fire = (state == PRESSED) && !key_s && (rpt_cnt == RPT_LAST);
`else
  assign rpt_fire = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    press_done = 1'b0;
    if (state == PRESS_WAIT && !key_s && deb_cnt == DEB_LAST) begin
      press_done = 1'b1;
    end
    accept = press_done | rpt_fire;
  end

  // Debounce FSM plus the registered accept outputs, all on one edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RELEASED;
      deb_cnt   <= '0;
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
      history   <= '0;
      bit_count <= '0;
    end else begin
      bit_valid <= accept;
      if (accept) begin
        bit_out   <= sw_s;
        history   <= (history << 1) | HIST_LEN'(sw_s);
        bit_count <= bit_count + 1'b1;
      end

      unique case (state)
        RELEASED: begin
          deb_cnt <= '0;
          if (!key_s) state <= PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (key_s) begin
            state   <= RELEASED;      // bounce: start over
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= PRESSED;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        PRESSED: begin
          deb_cnt <= '0;
          if (key_s) state <= RELEASE_WAIT;
        end
        RELEASE_WAIT: begin
          if (!key_s) begin
            state   <= PRESSED;       // short release: still the same press
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= RELEASED;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: begin
          state   <= RELEASED;
          deb_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_bit_sampler.sv
// -----------------------------------------------------------------------------
// tb_key_bit_sampler
// Scoreboard bench for key_bit_sampler (DEBOUNCE_CYCLES=4, HIST_LEN=4,
// REPEAT_CYCLES=10). A reference model, written in terms of run lengths of
// the synchronized key level, predicts each accept (cycle, bit, history,
// count) and queues it; an independent monitor compares DUT strobes against
// the queue. Directed scenarios add fixed-value checks on top.
// -----------------------------------------------------------------------------
module tb_key_bit_sampler;

  localparam int D = 4;
  localparam int H = 4;
  localparam int R = 10;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         key_n = 1'b1;
  logic         sw    = 1'b0;
  logic         bit_valid;
  logic         bit_out;
  logic [H-1:0] history;
  logic [7:0]   bit_count;

  key_bit_sampler #(
    .DEBOUNCE_CYCLES (D),
    .HIST_LEN        (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_n     (key_n),
    .sw        (sw),
    .bit_valid (bit_valid),
    .bit_out   (bit_out),
    .history   (history),
    .bit_count (bit_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           cyc;
    logic         b;
    logic [H-1:0] hist;
    logic [7:0]   cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pulses = 0;
  int   last_pulse_cyc = -1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Inputs become visible two clocks late. A press is
  // accepted when, starting from released, the key has been seen low for
  // D+1 consecutive clocks; a release likewise needs D+1 consecutive highs.
  // While pressed (auto-repeat builds), another accept comes every R clocks
  // of uninterrupted low, restarting whenever a short release ends.
  // ---------------------------------------------------------------------------
  logic         kd1, kd2, sd1, sd2, ks, ss;
  logic         m_pressed, run_val;
  int           run_len, age, m_count;
  logic [H-1:0] m_hist;

  task automatic model_reset();
    kd1 = 1'b1; kd2 = 1'b1; sd1 = 1'b0; sd2 = 1'b0;
    m_pressed = 1'b0; run_val = 1'b1; run_len = 0; age = 0;
    m_hist = '0; m_count = 0;
    exp_q.delete();
  endtask

  task automatic emit(input logic b);
    exp_t e;
    m_hist  = (m_hist << 1) | H'(b);
    m_count = (m_count + 1) % 256;
    e.cyc  = cyc;
    e.b    = b;
    e.hist = m_hist;
    e.cnt  = 8'(m_count);
    exp_q.push_back(e);
  endtask

  initial begin : model
    model_reset();
    forever begin
      @(posedge clock);
      cyc++;
      if (reset) begin
        model_reset();
      end else begin
        ks = kd2; ss = sd2;
        kd2 = kd1; kd1 = key_n;
        sd2 = sd1; sd1 = sw;
        if (ks == run_val) run_len++;
        else begin
          run_val = ks;
          run_len = 1;
        end
        if (!m_pressed && !ks && run_len == D + 1) begin
          m_pressed = 1'b1;
          age = 0;
          emit(ss);
        end else if (m_pressed && ks && run_len == D + 1) begin
          m_pressed = 1'b0;
        end else if (m_pressed && !ks) begin
          if (run_len == 1) age = 0;
          else begin
            age++;
`ifdef KEY_BIT_SAMPLER_AUTO_REPEAT_EN
            if (age == R) begin
              age = 0;
              emit(ss);
            end
`endif
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares each DUT strobe against the head of the queue and
  // flags expected strobes that never came.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (bit_valid === 1'b1) begin
        pulses++;
        last_pulse_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'(bit_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_bit_out", 32'(bit_out), 32'(e.b));
          check("pulse_history", 32'(history), 32'(e.hist));
          check("pulse_bit_count", 32'(bit_count), 32'(e.cnt));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        check("missing_pulse", 32'(bit_valid), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus (always driven just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic hold(input logic k, input int n);
    key_n = k;
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic v);
    sw = v;
    hold(1'b0, 8);
    hold(1'b1, 8);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    key_n = 1'b1;
    repeat (n) @(negedge clock);
    reset = 1'b0;
    hold(1'b1, 4);
  endtask

  task automatic check_outputs(input string tag, input logic b, input logic [H-1:0] h,
                               input logic [7:0] c);
    check({tag, "_bit_out"}, 32'(bit_out), 32'(b));
    check({tag, "_history"}, 32'(history), 32'(h));
    check({tag, "_bit_count"}, 32'(bit_count), 32'(c));
  endtask

  int           t0;
  int           p0;
  logic         v;
  logic [H-1:0] wrap_hist;

  initial begin : stimulus
    @(negedge clock);
    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_bit_valid", 32'(bit_valid), 32'd0);
    check_outputs("reset", 1'b0, '0, 8'd0);
    reset = 1'b0;
    hold(1'b1, 8);

    // Clean press with sw=1
    sw = 1'b1;
    t0 = cyc;
    hold(1'b0, 12);
    hold(1'b1, 12);
    check("clean_latency", last_pulse_cyc - t0, 32'd7);
    check_outputs("clean", 1'b1, 4'b0001, 8'd1);

    // Bouncy press with sw=0; glitches alone must not strobe
    sw = 1'b0;
    p0 = pulses;
    hold(1'b0, 2); hold(1'b1, 1); hold(1'b0, 2); hold(1'b1, 1);
    check("bounce_no_pulse", pulses - p0, 32'd0);
    t0 = cyc;
    hold(1'b0, 12);
    hold(1'b1, 12);
    check("bounce_latency", last_pulse_cyc - t0, 32'd7);
    check("bounce_one_pulse", pulses - p0, 32'd1);
    check_outputs("bounce", 1'b0, 4'b0010, 8'd2);

    // sw changes during the debounce window: value at the accept edge wins
    sw = 1'b0;
    hold(1'b0, 3);
    sw = 1'b1;
    hold(1'b0, 9);
    hold(1'b1, 12);
    check_outputs("sw_late", 1'b1, 4'b0101, 8'd3);

    // Sequence 0,0,1,0,1 from a clean reset
    do_reset(2);
    press(1'b0); press(1'b0); press(1'b1); press(1'b0); press(1'b1);
    check_outputs("sequence", 1'b1, 4'b0101, 8'd5);

    // Short release in the middle of a hold: still one bit
    sw = 1'b1;
    p0 = pulses;
    hold(1'b0, 10); hold(1'b1, 2); hold(1'b0, 8); hold(1'b1, 10);
    check("glitch_one_pulse", pulses - p0, 32'd1);
    check_outputs("glitch", 1'b1, 4'b1011, 8'd6);
    press(1'b0);
    check_outputs("after_glitch", 1'b0, 4'b0110, 8'd7);

    // Reset one cycle before the accept edge, key still held afterwards
    sw = 1'b1;
    p0 = pulses;
    hold(1'b0, 6);
    reset = 1'b1;
    #1;
    check("midreset_bit_valid", 32'(bit_valid), 32'd0);
    check_outputs("midreset", 1'b0, '0, 8'd0);
    repeat (2) @(negedge clock);
    check("midreset_no_pulse", pulses - p0, 32'd0);
    reset = 1'b0;
    t0 = cyc;
    hold(1'b0, 12);
    hold(1'b1, 12);
    check("postreset_latency", last_pulse_cyc - t0, 32'd7);
    check_outputs("postreset", 1'b1, 4'b0001, 8'd1);

    // Long hold: auto-repeat (if built in) adds three bits R clocks apart
    do_reset(2);
    sw = 1'b1;
    hold(1'b0, 7 + 35);
    hold(1'b1, 12);
`ifdef KEY_BIT_SAMPLER_AUTO_REPEAT_EN
    check_outputs("long_hold", 1'b1, 4'b1111, 8'd4);
`else
    check_outputs("long_hold", 1'b1, 4'b0001, 8'd1);
`endif

    // bit_count wraps 255 -> 0
    do_reset(2);
    wrap_hist = '0;
    for (int i = 0; i < 256; i++) begin
      v = 1'($urandom_range(0, 1));
      wrap_hist = (wrap_hist << 1) | H'(v);
      sw = v;
      hold(1'b0, 6);
      hold(1'b1, 6);
    end
    check_outputs("wrap", wrap_hist[0], wrap_hist, 8'd0);

    // Random key/switch activity, occasional resets; scoreboard checks all
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clock);
        reset = 1'b0;
      end
      sw = 1'($urandom_range(0, 1));
      key_n = ~key_n;
      repeat ($urandom_range(1, 7)) @(negedge clock);
      if ($urandom_range(0, 3) == 0) sw = ~sw;
      repeat ($urandom_range(0, 7)) @(negedge clock);
    end

    hold(1'b1, 20);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
